// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, register constants and parameter defaults for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} pipe_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CNT_W_DEF = 32;
  localparam int TIMEOUT_DEF = 64;
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return rd != REG_ZERO && rd == rs;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: datapath-to-controller hazard inputs and stage-control outputs
interface pipe_ctrl_if;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
  logic id_branch_i, id_eq_i, ex_memread_i, ex_regwrite_i, mem_memread_i, mem_req_i, mem_ready_i;
  logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o;
  modport master(
    output id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, id_branch_i, id_eq_i, ex_memread_i,
           ex_regwrite_i, mem_memread_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o
  );
  modport slave(
    input  id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, id_branch_i, id_eq_i, ex_memread_i,
           ex_regwrite_i, mem_memread_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o
  );
endinterface

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: load-use and branch-operand dependency comparators (x0 never matches)
module pipe_hazard_detect import pipe_ctrl_pkg::*; (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] ex_rd,
  input  logic [4:0] mem_rd,
  input  logic       id_branch,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic       mem_memread,
  output logic       lu,
  output logic       br
);
  logic ex_hit, mem_hit;
  assign ex_hit = reg_hit(ex_rd, rs1) | reg_hit(ex_rd, rs2);
  assign mem_hit = reg_hit(mem_rd, rs1) | reg_hit(mem_rd, rs2);
  assign lu = ex_memread & ex_hit;
  assign br = id_branch & ((ex_regwrite & ex_hit) | (mem_memread & mem_hit));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/freeze controller with run gating and memory-wait timeout.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush/freeze counters; otherwise they read 0.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  pipe_ctrl_if.slave       bus,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  pipe_state_e state, state_nx;
  logic [WW-1:0] wcnt;
  logic lu, br, stall, wait_mem, tmo, run, freeze, stall_act, flush_act;
  pipe_hazard_detect u_hazard (
    .rs1(bus.id_rs1_i), .rs2(bus.id_rs2_i), .ex_rd(bus.ex_rd_i), .mem_rd(bus.mem_rd_i),
    .id_branch(bus.id_branch_i), .ex_memread(bus.ex_memread_i),
    .ex_regwrite(bus.ex_regwrite_i), .mem_memread(bus.mem_memread_i),
    .lu(lu), .br(br)
  );
  assign stall = lu | br;
  assign wait_mem = bus.mem_req_i & ~bus.mem_ready_i;
  assign tmo = state == MEM_WAIT && wcnt == W_LAST;
  assign run = state != IDLE;
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // an outstanding access must be released before start_i can drop the pipeline to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = start_i ? RUN : IDLE;
      RUN:      state_nx = wait_mem ? MEM_WAIT : start_i ? RUN : IDLE;
      MEM_WAIT: state_nx = (bus.mem_ready_i | tmo) ? RUN : MEM_WAIT;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    freeze = run & wait_mem & ~tmo;
    stall_act = run & ~freeze & stall;
    flush_act = run & ~freeze & ~stall & bus.id_branch_i & bus.id_eq_i;
    bus.pc_write_o = run & ~freeze & ~stall;
    bus.ifid_write_o = run & ~freeze & ~stall;
    bus.ifid_flush_o = flush_act;
    bus.idex_bubble_o = ~run | stall_act;
    bus.pipe_freeze_o = freeze;
  end
  // wait counter is held at zero outside MEM_WAIT, so it starts from zero on every entry
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wcnt <= '0;
      err_o <= 1'b0;
    end else begin
      wcnt <= state == MEM_WAIT ? wcnt + 1'b1 : '0;
      if (tmo) err_o <= 1'b1;
    end
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
      freeze_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(stall_act && !(&stall_q));
      flush_q <= flush_q + CNT_W'(flush_act && !(&flush_q));
      freeze_q <= freeze_q + CNT_W'(freeze && !(&freeze_q));
    end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
  assign freeze_cnt_o = freeze_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign freeze_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, directed corner sequences and random stimulus checked against a behavioural model
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX = 15;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [4:0] rs1, rs2;
    logic br, eq, exmr, exrw;
    logic [4:0] exrd;
    logic memmr;
    logic [4:0] memrd;
    logic req, rdy;
  } in_t;
  typedef struct {
    in_t i;
    logic [4:0] e;
  } vec_t;
  logic clk = 1'b0, rst, start, err;
  logic [CNT_W-1:0] scnt, fcnt, zcnt;
  pipe_ctrl_if bus();
  pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus), .err_o(err),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt), .freeze_cnt_o(zcnt)
  );
  always #5 clk = ~clk;
  int total = 0, passed = 0;
  // model: 0 = stopped, 1 = running, 2 = waiting on memory
  int m_st = 0, m_w = 0, m_s = 0, m_f = 0, m_z = 0;
  bit m_err = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  function automatic in_t mkin(input int rs1, rs2, br, eq, exmr, exrw, exrd, memmr, memrd, req, rdy);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.br = 1'(br); v.eq = 1'(eq);
    v.exmr = 1'(exmr); v.exrw = 1'(exrw); v.exrd = 5'(exrd);
    v.memmr = 1'(memmr); v.memrd = 5'(memrd); v.req = 1'(req); v.rdy = 1'(rdy);
    return v;
  endfunction
  task automatic drive(input in_t v);
    bus.id_rs1_i = v.rs1; bus.id_rs2_i = v.rs2; bus.id_branch_i = v.br; bus.id_eq_i = v.eq;
    bus.ex_memread_i = v.exmr; bus.ex_regwrite_i = v.exrw; bus.ex_rd_i = v.exrd;
    bus.mem_memread_i = v.memmr; bus.mem_rd_i = v.memrd;
    bus.mem_req_i = v.req; bus.mem_ready_i = v.rdy;
  endtask
  function automatic bit dep(input logic [4:0] rd);
    return rd != 0 && (rd == bus.id_rs1_i || rd == bus.id_rs2_i);
  endfunction
  // expected {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  function automatic logic [4:0] model_out();
    bit hazard, timed_out;
    hazard = (bus.ex_memread_i && dep(bus.ex_rd_i)) ||
             (bus.id_branch_i && ((bus.ex_regwrite_i && dep(bus.ex_rd_i)) ||
                                  (bus.mem_memread_i && dep(bus.mem_rd_i))));
    timed_out = m_st == 2 && m_w == TIMEOUT - 1;
    if (m_st == 0) return 5'b00010;
    if (bus.mem_req_i && !bus.mem_ready_i && !timed_out) return 5'b00001;
    if (hazard) return 5'b00010;
    if (bus.id_branch_i && bus.id_eq_i) return 5'b11100;
    return 5'b11000;
  endfunction
  task automatic model_step();
    logic [4:0] o;
    bit timed_out;
    if (rst) begin
      m_st = 0; m_w = 0; m_s = 0; m_f = 0; m_z = 0; m_err = 1'b0;
    end else begin
      o = model_out();
      timed_out = m_st == 2 && m_w == TIMEOUT - 1;
      if (m_st != 0) begin
        if (o[0]) m_z = m_z == CMAX ? CMAX : m_z + 1;
        if (o[1]) m_s = m_s == CMAX ? CMAX : m_s + 1;
        if (o[2]) m_f = m_f == CMAX ? CMAX : m_f + 1;
      end
      if (timed_out) m_err = 1'b1;
      if (m_st == 0) begin
        if (start) m_st = 1;
      end else if (m_st == 1) begin
        if (bus.mem_req_i && !bus.mem_ready_i) begin m_st = 2; m_w = 0; end
        else if (!start) m_st = 0;
      end else begin
        if (bus.mem_ready_i || timed_out) m_st = 1;
        else m_w++;
      end
    end
  endtask
  // entered one time unit after a rising edge with inputs already driven
  task automatic tick(input string name, output logic [4:0] o);
    #4;
    o = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_bubble_o, bus.pipe_freeze_o};
    check({name, " outs"}, 32'(o), 32'(model_out()));
    @(posedge clk);
    model_step();
    #1;
    check({name, " stall_cnt"}, 32'(scnt), PERF ? m_s : 0);
    check({name, " flush_cnt"}, 32'(fcnt), PERF ? m_f : 0);
    check({name, " freeze_cnt"}, 32'(zcnt), PERF ? m_z : 0);
    check({name, " err"}, 32'(err), 32'(m_err));
  endtask
  vec_t vt[14];
  initial begin
    logic [4:0] o;
    logic [CNT_W-1:0] s0, f0, z0;
    in_t q, v;
    q = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = '{mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11000};
    vt[1]  = '{mkin(1, 5, 0, 0, 1, 0, 5, 0, 0, 0, 0), 5'b00010};
    vt[2]  = '{mkin(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0), 5'b11000};
    vt[3]  = '{mkin(2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0), 5'b11100};
    vt[4]  = '{mkin(2, 3, 1, 1, 0, 1, 2, 0, 0, 0, 0), 5'b00010};
    vt[5]  = '{mkin(2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0), 5'b11100};
    vt[6]  = '{mkin(2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11000};
    vt[7]  = '{mkin(2, 3, 0, 0, 0, 1, 2, 0, 0, 0, 0), 5'b11000};
    vt[8]  = '{mkin(4, 7, 1, 1, 0, 0, 0, 1, 7, 0, 0), 5'b00010};
    vt[9]  = '{mkin(4, 7, 0, 0, 0, 0, 0, 1, 7, 0, 0), 5'b11000};
    vt[10] = '{mkin(4, 7, 1, 1, 0, 0, 0, 0, 0, 1, 1), 5'b11100};
    vt[11] = '{mkin(6, 9, 1, 1, 1, 0, 9, 0, 0, 0, 0), 5'b00010};
    vt[12] = '{mkin(0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0), 5'b11100};
    vt[13] = '{mkin(4, 7, 1, 1, 0, 0, 0, 1, 9, 0, 0), 5'b11100};
    rst = 1'b1; start = 1'b0; drive(q);
    @(posedge clk);
    model_step();
    #1;
    tick("reset", o);
    check("reset state outs", 32'(o), 32'(5'b00010));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("idle", o);
      check("idle pc_write", 32'(o[4]), 0);
      check("idle bubble", 32'(o[1]), 1);
    end
    check("idle stall_cnt zero", 32'(scnt), 0);
    start = 1'b1;
    tick("start sample", o);
    check("start sample still idle", 32'(o), 32'(5'b00010));
    tick("run default", o);
    check("run default outs", 32'(o), 32'(5'b11000));
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].i);
      tick($sformatf("vec%0d", i), o);
      check($sformatf("vec%0d table", i), 32'(o), 32'(vt[i].e));
    end
    drive(q);
    tick("settle", o);
    s0 = scnt; f0 = fcnt; z0 = zcnt;
    drive(mkin(6, 9, 1, 1, 1, 0, 9, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      tick("freeze", o);
      check("freeze outs", 32'(o), 32'(5'b00001));
    end
    check("freeze holds stall_cnt", 32'(scnt), 32'(s0));
    check("freeze holds flush_cnt", 32'(fcnt), 32'(f0));
    check("freeze_cnt +4", 32'(zcnt), PERF ? (int'(z0) + 4 > CMAX ? CMAX : int'(z0) + 4) : 0);
    bus.mem_ready_i = 1'b1;
    tick("ready", o);
    check("ready cycle not frozen", 32'(o), 32'(5'b00010));
    drive(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 9; i++) begin
      tick("timeout", o);
      check($sformatf("timeout cycle %0d", i), 32'(o), i <= 8 ? 32'(5'b00001) : 32'(5'b11000));
      if (i == 8) check("err before timeout", 32'(err), 0);
    end
    check("err set by timeout", 32'(err), 1);
    tick("refreeze", o);
    check("refreeze after timeout", 32'(o), 32'(5'b00001));
    rst = 1'b1;
    tick("mid-freeze reset", o);
    check("reset clears err", 32'(err), 0);
    rst = 1'b0; drive(q);
    tick("restart", o);
    check("restart idle", 32'(o), 32'(5'b00010));
    drive(mkin(1, 5, 0, 0, 1, 0, 5, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) tick("saturate", o);
    check("stall_cnt saturated", 32'(scnt), PERF ? CMAX : 0);
    for (int i = 0; i < 600; i++) begin
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.exrd = 5'($urandom_range(0, 3)); v.memrd = 5'($urandom_range(0, 3));
      v.br = 1'($urandom); v.eq = 1'($urandom); v.exmr = 1'($urandom); v.exrw = 1'($urandom);
      v.memmr = 1'($urandom); v.req = 1'($urandom_range(0, 2) == 0);
      v.rdy = 1'($urandom_range(0, 5) == 0);
      drive(v);
      start = 1'($urandom_range(0, 15) != 0);
      rst = 1'($urandom_range(0, 79) == 0);
      tick("random", o);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage RISC-V CPU. Combines load-use and branch-operand hazard detection, branch-taken flush, and a freeze for multi-cycle data-memory accesses into one set of stage enables. Also gates the whole pipeline on `start_i` and keeps stall, flush and freeze performance counters. Sits beside the CPU datapath: it receives register addresses and control bits from ID, EX and MEM, and drives the PC, IF/ID, ID/EX and EX/MEM write and bubble controls.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `TIMEOUT`, default 64: maximum number of MEM_WAIT cycles before a forced release.
- `clk_i` in 1: the only clock. All state updates on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: run enable.
- `id_rs1_i`, `id_rs2_i` in 5: source registers of the ID instruction.
- `id_branch_i` in 1: ID instruction is a branch.
- `id_eq_i` in 1: ID branch condition is true (branch taken).
- `ex_memread_i`, `ex_regwrite_i` in 1: control bits of the EX instruction.
- `ex_rd_i` in 5: destination register of the EX instruction.
- `mem_memread_i` in 1: the MEM instruction is a load.
- `mem_rd_i` in 5: destination register of the MEM instruction.
- `mem_req_i` in 1: the MEM stage is issuing a load or store.
- `mem_ready_i` in 1: data memory completes the access this cycle.
- `pc_write_o`, `ifid_write_o` out 1: write enables for the PC and IF/ID.
- `ifid_flush_o` out 1: clear IF/ID to NOP.
- `idex_bubble_o` out 1: load a bubble into ID/EX.
- `pipe_freeze_o` out 1: hold every pipeline register, including EX/MEM and MEM/WB.
- `err_o` out 1: sticky memory-timeout flag.
- `stall_cnt_o`, `flush_cnt_o`, `freeze_cnt_o` out `CNT_W`: performance counters.

## Operation
**States.** Three states, encoded as `IDLE`, `RUN`, `MEM_WAIT`.
- IDLE → RUN when `start_i` = 1.
- RUN → MEM_WAIT when `mem_req_i & ~mem_ready_i`.
- MEM_WAIT → RUN when `mem_ready_i` = 1, or when the wait counter reaches `TIMEOUT-1`.
- RUN → IDLE when `start_i` = 0.
- From MEM_WAIT, `start_i` = 0 takes effect only after the access is released.

**Hazard terms.** Register x0 never matches.
- `lu` = `ex_memread_i` and `ex_rd_i` equals rs1 or rs2.
- `br` = `id_branch_i` and one of:
  - `ex_regwrite_i` with `ex_rd_i` matching rs1 or rs2, or
  - `mem_memread_i` with `mem_rd_i` matching rs1 or rs2.
- `stall` = `lu | br`.

**Output priority, highest first.**
1. IDLE: `pc_write_o` = 0, `ifid_write_o` = 0, `idex_bubble_o` = 1. Counters hold.
2. Freeze: active when `mem_req_i & ~mem_ready_i` and the timeout is not firing. Sets `pipe_freeze_o` = 1 and `pc_write_o` = `ifid_write_o` = 0. Both flush and bubble are suppressed.
3. Stall: `pc_write_o` = `ifid_write_o` = 0 and `idex_bubble_o` = 1. Flush is suppressed, because an unresolved branch must not flush.
4. Taken branch (`id_branch_i & id_eq_i`): `ifid_flush_o` = 1. PC and IF/ID writes stay enabled.
5. Otherwise, all write enables are 1 and flush and bubble are 0.

**Counters.**
- `stall_cnt_o` increments on each cycle where case 3 is active.
- `flush_cnt_o` increments on each cycle where case 4 is active.
- `freeze_cnt_o` increments on each cycle where case 2 is active.
- All counters saturate at all-ones. They are cleared only by `rst_i`.

**Timeout.**
- The wait counter clears on entry to MEM_WAIT.
- On the cycle the wait counter equals `TIMEOUT-1`, `err_o` sets and the freeze is dropped for that cycle (the access is treated as complete).
- `err_o` stays set until `rst_i`.

## Timing
- Hazard, flush and freeze outputs are combinational from the current state and inputs, valid in the same cycle.
- State, the wait counter, the performance counters and `err_o` update on `clk_i`.
- Reset values:
  - State = IDLE, so `pc_write_o` = 0, `ifid_write_o` = 0, `idex_bubble_o` = 1, `ifid_flush_o` = 0, `pipe_freeze_o` = 0.
  - `err_o` = 0 and all counters = 0.
- `rst_i` overrides everything, mid-stall or mid-freeze included. The controller is in IDLE on the next cycle.
- A `start_i` rising edge gives RUN outputs from the cycle after it is sampled.
- A freeze ends in the cycle `mem_ready_i` = 1. The ready cycle itself is not frozen.
- A load-use hazard produces exactly one stall cycle. A load followed by a dependent branch produces two stall cycles.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: the three counters and their saturation logic are built.
- `PIPE_CTRL_PERF_EN` undefined: the counter outputs are tied to 0 and no counter flops exist. Hazard, freeze, timeout and state behaviour are unchanged.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum `pipe_state_e` (`IDLE`, `RUN`, `MEM_WAIT`),
  - the x0 register constant `REG_ZERO`,
  - default values for `CNT_W` and `TIMEOUT`.
- Sub-module `pipe_hazard_detect` holds the combinational `lu`/`br` comparators. `pipe_ctrl` holds the FSM, output priority, counters and timeout.

## Test plan
1. Reset, then `start_i` = 0 for 3 cycles → `pc_write_o` = 0 and `idex_bubble_o` = 1 throughout, all counters 0. Raise `start_i` → outputs switch to the RUN defaults the next cycle.
2. `ex_memread_i` = 1, `ex_rd_i` = 5, `id_rs2_i` = 5 for one cycle → one cycle with `pc_write_o` = 0 and `idex_bubble_o` = 1, `stall_cnt_o` = 1. Repeat with `ex_rd_i` = 0 → no stall.
3. Taken branch with no dependency → `ifid_flush_o` = 1 for one cycle, `flush_cnt_o` = 1. Same branch with `ex_regwrite_i` = 1 and `ex_rd_i` = rs1 → stall, no flush that cycle; flush on the following cycle.
4. `mem_req_i` = 1 with `mem_ready_i` low for 4 cycles, then high → `pipe_freeze_o` high for 4 cycles, `freeze_cnt_o` = 4. A simultaneous load-use hazard and taken branch are held, and neither `stall_cnt_o` nor `flush_cnt_o` increments during the freeze.
5. With `TIMEOUT` = 8, hold `mem_ready_i` = 0 → `err_o` sets in the 8th MEM_WAIT cycle, the freeze drops and the state returns to RUN. Assert `rst_i` → `err_o` = 0.
6. Preload the counters near all-ones (`CNT_W` = 4) and keep stalling → `stall_cnt_o` holds at 15. With `PIPE_CTRL_PERF_EN` undefined → all counters read 0.
